// File: rtl/t05_translation_ctrl.sv
// rtl/t05_translation_ctrl.sv - Huffman translation stage sequencer
module t05_translation_ctrl #(
  parameter int ADDR_W = 32,
  parameter int PATH_W = 128,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] totChar,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              char_req,
  output logic [ADDR_W-1:0] char_addr,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              code_req,
  output logic [7:0]        code_char,
  input  logic              code_valid,
  input  logic [PATH_W-1:0] code_path,
  input  logic [LEN_W-1:0]  code_len,
  output logic [7:0]        charIn,
  output logic [PATH_W-1:0] path,
  output logic [LEN_W-1:0]  path_len,
  output logic              trn_go,
  input  logic              trn_done,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] charCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_CHAR,
    S_RD_CODE,
    S_ISSUE,
    S_WAIT_TRN,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [31:0] MAX_LEN = 32'(PATH_W);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] tot_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] index_q;
  logic [ADDR_W-1:0] index_inc;
  logic              len_bad;

  assign index_inc = index_q + ADDR_W'(1);
  // Zero-length codes and codes longer than the path bus cannot be translated.
  assign len_bad   = (code_len == '0) || (32'(code_len) > MAX_LEN);
  // Address wraps modulo 2^ADDR_W; base and index are both cleared by reset.
  assign char_addr = base_q + index_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection and per-state handshake outputs.
  always_comb begin
    state_nxt = state;
    char_req  = 1'b0;
    code_req  = 1'b0;
    trn_go    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (totChar == '0) ? S_DONE : S_RD_CHAR;
        end
      end
      S_RD_CHAR: begin
        char_req = 1'b1;
        busy     = 1'b1;
        if (char_valid) begin
          state_nxt = S_RD_CODE;
        end
      end
      S_RD_CODE: begin
        code_req = 1'b1;
        busy     = 1'b1;
        if (code_valid) begin
          state_nxt = len_bad ? S_ERR : S_ISSUE;
        end
      end
      S_ISSUE: begin
        trn_go    = 1'b1;
        busy      = 1'b1;
        state_nxt = S_WAIT_TRN;
      end
      S_WAIT_TRN: begin
        busy = 1'b1;
        if (trn_done) begin
          state_nxt = (index_inc == tot_q) ? S_DONE : S_RD_CHAR;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Pass parameters, lookup results, counters and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tot_q     <= '0;
      base_q    <= '0;
      index_q   <= '0;
      charCount <= '0;
      error     <= 1'b0;
      code_char <= '0;
      charIn    <= '0;
      path      <= '0;
      path_len  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            tot_q     <= totChar;
            base_q    <= base_addr;
            index_q   <= '0;
            charCount <= '0;
            error     <= 1'b0;
          end
        end
        S_RD_CHAR: begin
          if (char_valid) begin
            code_char <= char_data;
          end
        end
        S_RD_CODE: begin
          if (code_valid) begin
            if (len_bad) begin
              error <= 1'b1;
            end else begin
              // Translation inputs only change when a new character is issued.
              charIn   <= code_char;
              path     <= code_path;
              path_len <= code_len;
            end
          end
        end
        S_WAIT_TRN: begin
          if (trn_done) begin
            index_q   <= index_inc;
            charCount <= charCount + ADDR_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_t05_translation_ctrl.sv
// tb/tb_t05_translation_ctrl.sv - directed bench for t05_translation_ctrl
module tb_t05_translation_ctrl;

  logic         clk;
  logic         rst;
  logic         start;
  logic [31:0]  totChar;
  logic [31:0]  base_addr;
  logic         char_req;
  logic [31:0]  char_addr;
  logic         char_valid;
  logic [7:0]   char_data;
  logic         code_req;
  logic [7:0]   code_char;
  logic         code_valid;
  logic [127:0] code_path;
  logic [7:0]   code_len;
  logic [7:0]   charIn;
  logic [127:0] path;
  logic [7:0]   path_len;
  logic         trn_go;
  logic         trn_done;
  logic         trn_done_auto;
  logic         trn_done_man;
  logic         busy;
  logic         done;
  logic         error;
  logic [31:0]  charCount;

  int n_cmp = 0;
  int n_mis = 0;

  int char_lat = 1;
  int code_lat = 1;
  int bad_lookup = 0;
  int lookups = 0;
  bit trn_en = 1'b1;
  int done_cnt = 0;
  int char_req_cycles = 0;
  int code_req_cycles = 0;

  logic [31:0]  addr_log[$];
  logic [7:0]   ch_log[$];
  logic [127:0] path_log[$];
  logic [7:0]   len_log[$];

  logic [7:0]   cmem[4];
  logic [7:0]   exp_ch[3];
  logic [127:0] exp_path[3];
  logic [7:0]   exp_len[3];

  assign trn_done = trn_done_auto | trn_done_man;

  t05_translation_ctrl #(.ADDR_W(32), .PATH_W(128), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .totChar(totChar), .base_addr(base_addr),
    .char_req(char_req), .char_addr(char_addr), .char_valid(char_valid), .char_data(char_data),
    .code_req(code_req), .code_char(code_char), .code_valid(code_valid),
    .code_path(code_path), .code_len(code_len),
    .charIn(charIn), .path(path), .path_len(path_len), .trn_go(trn_go), .trn_done(trn_done),
    .busy(busy), .done(done), .error(error), .charCount(charCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Character SRAM model: valid after char_lat request cycles.
  initial begin
    int cnt;
    logic [31:0] off;
    cnt = 0;
    char_valid = 1'b0;
    char_data = 8'h00;
    forever begin
      @(negedge clk);
      char_valid = 1'b0;
      if (char_req) begin
        char_req_cycles++;
        if (cnt == char_lat) begin
          off = char_addr - 32'h100;
          char_valid = 1'b1;
          char_data = cmem[off[1:0]];
          addr_log.push_back(char_addr);
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Code-table SRAM model: A and B codes, optional bad length on a chosen lookup.
  initial begin
    int cnt;
    cnt = 0;
    code_valid = 1'b0;
    code_path = '0;
    code_len = 8'd0;
    forever begin
      @(negedge clk);
      code_valid = 1'b0;
      if (code_req) begin
        code_req_cycles++;
        if (cnt == code_lat) begin
          lookups++;
          code_valid = 1'b1;
          if (code_char == 8'd65) begin
            code_path = 128'h40000A;
            code_len = 8'd4;
          end else if (code_char == 8'd66) begin
            code_path = 128'h861;
            code_len = 8'd12;
          end else begin
            code_path = 128'h1;
            code_len = 8'd1;
          end
          if (lookups == bad_lookup) code_len = 8'd0;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Translation block model: logs each issue, completes 10 cycles later.
  initial begin
    int cd;
    cd = 0;
    trn_done_auto = 1'b0;
    forever begin
      @(negedge clk);
      trn_done_auto = 1'b0;
      if (trn_go) begin
        ch_log.push_back(charIn);
        path_log.push_back(path);
        len_log.push_back(path_len);
        if (trn_en) cd = 10;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) trn_done_auto = 1'b1;
      end
    end
  end

  // Count done pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string p);
    check({p, "/char_req"}, 128'(char_req), 128'(0));
    check({p, "/code_req"}, 128'(code_req), 128'(0));
    check({p, "/trn_go"}, 128'(trn_go), 128'(0));
    check({p, "/busy"}, 128'(busy), 128'(0));
    check({p, "/done"}, 128'(done), 128'(0));
    check({p, "/error"}, 128'(error), 128'(0));
    check({p, "/charCount"}, 128'(charCount), 128'(0));
    check({p, "/char_addr"}, 128'(char_addr), 128'(0));
    check({p, "/code_char"}, 128'(code_char), 128'(0));
    check({p, "/charIn"}, 128'(charIn), 128'(0));
    check({p, "/path"}, path, 128'(0));
    check({p, "/path_len"}, 128'(path_len), 128'(0));
  endtask

  task automatic do_start(input logic [31:0] tot, input logic [31:0] base);
    start = 1'b1;
    totChar = tot;
    base_addr = base;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string p);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done || error) begin
        ok = 1'b1;
        break;
      end
    end
    check({p, "/finished"}, 128'(ok), 128'(1));
  endtask

  task automatic wait_issue(input string p, input int n0);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ch_log.size() > n0) begin
        ok = 1'b1;
        break;
      end
    end
    check({p, "/issued"}, 128'(ok), 128'(1));
  endtask

  task automatic chk_three(input string p, input int a0, input int n0);
    check({p, "/n_addr"}, 128'(addr_log.size() - a0), 128'(3));
    check({p, "/n_go"}, 128'(ch_log.size() - n0), 128'(3));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s/addr%0d", p, i), 128'(addr_log[a0 + i]), 128'(32'h100 + i));
      check($sformatf("%s/charIn%0d", p, i), 128'(ch_log[n0 + i]), 128'(exp_ch[i]));
      check($sformatf("%s/path%0d", p, i), path_log[n0 + i], exp_path[i]);
      check($sformatf("%s/len%0d", p, i), 128'(len_log[n0 + i]), 128'(exp_len[i]));
    end
  endtask

  initial begin
    int a0;
    int n0;
    int d0;
    int r0;
    int q0;
    cmem[0] = 8'd65; cmem[1] = 8'd66; cmem[2] = 8'd65; cmem[3] = 8'd0;
    exp_ch[0] = 8'd65; exp_ch[1] = 8'd66; exp_ch[2] = 8'd65;
    exp_path[0] = 128'h40000A; exp_path[1] = 128'h861; exp_path[2] = 128'h40000A;
    exp_len[0] = 8'd4; exp_len[1] = 8'd12; exp_len[2] = 8'd4;
    rst = 1'b1;
    start = 1'b0;
    totChar = '0;
    base_addr = '0;
    trn_done_man = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Three characters with zero-wait memories.
    a0 = addr_log.size(); n0 = ch_log.size(); d0 = done_cnt;
    do_start(32'd3, 32'h100);
    wait_end("three");
    @(negedge clk);
    chk_three("three", a0, n0);
    check("three/done_cnt", 128'(done_cnt - d0), 128'(1));
    check("three/charCount", 128'(charCount), 128'(3));
    check("three/error", 128'(error), 128'(0));
    check("three/busy", 128'(busy), 128'(0));

    // Zero-length pass.
    r0 = char_req_cycles; d0 = done_cnt;
    do_start(32'd0, 32'h100);
    check("zero/done", 128'(done), 128'(1));
    check("zero/busy", 128'(busy), 128'(0));
    @(negedge clk);
    check("zero/done_after", 128'(done), 128'(0));
    check("zero/charCount", 128'(charCount), 128'(0));
    check("zero/char_req", 128'(char_req_cycles - r0), 128'(0));
    check("zero/done_cnt", 128'(done_cnt - d0), 128'(1));

    // Bad code length on the second lookup.
    bad_lookup = lookups + 2;
    n0 = ch_log.size(); d0 = done_cnt;
    do_start(32'd3, 32'h100);
    wait_end("bad");
    check("bad/error", 128'(error), 128'(1));
    check("bad/busy", 128'(busy), 128'(0));
    @(negedge clk);
    check("bad/error_sticky", 128'(error), 128'(1));
    check("bad/n_go", 128'(ch_log.size() - n0), 128'(1));
    check("bad/charCount", 128'(charCount), 128'(1));
    check("bad/done_cnt", 128'(done_cnt - d0), 128'(0));
    bad_lookup = 0;
    do_start(32'd0, 32'h0);
    check("bad/error_cleared", 128'(error), 128'(0));
    @(negedge clk);

    // Start while busy is ignored.
    a0 = addr_log.size(); n0 = ch_log.size(); d0 = done_cnt;
    do_start(32'd3, 32'h100);
    wait_issue("ign", n0);
    repeat (2) @(negedge clk);
    do_start(32'd7, 32'h200);
    wait_end("ign");
    @(negedge clk);
    chk_three("ign", a0, n0);
    check("ign/done_cnt", 128'(done_cnt - d0), 128'(1));
    check("ign/charCount", 128'(charCount), 128'(3));

    // Wait-state memories.
    char_lat = 6; code_lat = 3;
    a0 = addr_log.size(); n0 = ch_log.size(); d0 = done_cnt;
    r0 = char_req_cycles; q0 = code_req_cycles;
    do_start(32'd3, 32'h100);
    wait_end("wait");
    @(negedge clk);
    chk_three("wait", a0, n0);
    check("wait/done_cnt", 128'(done_cnt - d0), 128'(1));
    check("wait/charCount", 128'(charCount), 128'(3));
    check("wait/error", 128'(error), 128'(0));
    check("wait/char_req_cycles", 128'(char_req_cycles - r0), 128'(21));
    check("wait/code_req_cycles", 128'(code_req_cycles - q0), 128'(12));
    char_lat = 1; code_lat = 1;

    // Reset held mid-pass in WAIT_TRN; a late trn_done must be ignored.
    trn_en = 1'b0;
    n0 = ch_log.size();
    do_start(32'd3, 32'h100);
    wait_issue("rst", n0);
    @(negedge clk);
    check("rst/busy_before", 128'(busy), 128'(1));
    d0 = done_cnt;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk_zero("rst");
    rst = 1'b0;
    @(negedge clk);
    trn_done_man = 1'b1;
    @(negedge clk);
    trn_done_man = 1'b0;
    repeat (3) @(negedge clk);
    check("rst/done_cnt", 128'(done_cnt - d0), 128'(0));
    check("rst/charCount", 128'(charCount), 128'(0));
    check("rst/busy", 128'(busy), 128'(0));
    check("rst/char_req", 128'(char_req), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/t05_translation_ctrl.md
Name: t05_translation_ctrl

Overview:
Sequencer for the Huffman translation stage. On start it walks the input character buffer for totChar characters. For each character it reads the character, looks up its code path and length in the code table, then hands the pair to the translation datapath and waits for completion. It sits between the character SRAM, the code-table SRAM and the translation block, and reports done/error to the top-level FSM.

Parameters:
ADDR_W, 32, width of character buffer address and character counter
PATH_W, 128, width of code path bus
LEN_W, 8, width of code length field (valid lengths 1..PATH_W)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
start  in  1  single-cycle pulse; begins a pass when idle
totChar  in  ADDR_W  number of characters to translate; sampled on accepted start
base_addr  in  ADDR_W  character buffer base address; sampled on accepted start
char_req  out  1  character read request, held until char_valid
char_addr  out  ADDR_W  base_addr + index
char_valid  in  1  char_data valid; one-cycle pulse
char_data  in  8  character read
code_req  out  1  code-table read request, held until code_valid
code_char  out  8  character being looked up
code_valid  in  1  code_path/code_len valid; one-cycle pulse
code_path  in  PATH_W  code bits for code_char
code_len  in  LEN_W  number of valid bits in code_path
charIn  out  8  character to translation block
path  out  PATH_W  path to translation block
path_len  out  LEN_W  length to translation block
trn_go  out  1  one-cycle pulse; charIn/path/path_len valid
trn_done  in  1  one-cycle pulse from translation block; character fully emitted
busy  out  1  high from accepted start until DONE/ERR exit
done  out  1  one-cycle pulse on successful completion
error  out  1  sticky until next accepted start or rst
charCount  out  ADDR_W  characters completed in the current pass

Behaviour:
- Reset (rst=1 at a clock edge, from any state): state=IDLE. All outputs 0: char_req, code_req, trn_go, busy, done, error, charCount, char_addr, code_char, charIn, path, path_len. Internal index=0. A pending handshake is abandoned; late char_valid/code_valid/trn_done are ignored in IDLE.
- States: IDLE, RD_CHAR, RD_CODE, ISSUE, WAIT_TRN, DONE, ERR.
- IDLE: on start=1, latch totChar, base_addr, clear error/charCount/index, and set busy.
  - If the latched totChar==0, go to DONE.
  - Otherwise go to RD_CHAR.
  - start while not in IDLE is ignored.
- RD_CHAR: char_req=1, char_addr=base+index. On char_valid, latch char_data into code_char/charIn, drop char_req the next cycle, and go to RD_CODE.
- RD_CODE: code_req=1. On code_valid:
  - If code_len==0 or code_len>PATH_W, go to ERR.
  - Otherwise latch path/path_len and go to ISSUE.
- ISSUE: trn_go=1 for exactly one cycle, then go to WAIT_TRN. charIn/path/path_len stay stable until the next ISSUE or reset.
- WAIT_TRN: on trn_done, charCount+1 and index+1.
  - If the new index==totChar, go to DONE.
  - Otherwise go to RD_CHAR.
  - trn_done in any other state is ignored.
- DONE: done=1 for one cycle, busy=0, then IDLE. charCount holds its final value.
- ERR: error=1 (sticky), busy=0, then IDLE. charCount holds the count of completed characters.
- Minimum per-character latency with zero-wait memories (valid the cycle after req): 5 cycles from RD_CHAR entry to the next RD_CHAR entry, plus translation time.
- Address arithmetic is modulo 2^ADDR_W; base_addr+index wraps silently.
- Simultaneous start with rst: rst wins.

Test Plan:
- Reset: hold rst 4 cycles mid-pass (in WAIT_TRN) -> all outputs 0, state IDLE; a later trn_done pulse produces no done and charCount stays 0.
- Three chars: base=0x100, totChar=3, buffer 65,66,65; table A=path 0x40000A len 4, B=path 0x861 len 12; trn_done 10 cycles after each trn_go.
  - char_addr sequence is 0x100, 0x101, 0x102.
  - trn_go sees (65, 0x40000A, 4), (66, 0x861, 12), (65, 0x40000A, 4).
  - done pulses once, charCount=3, error=0.
- Zero length: start with totChar=0 -> no char_req; done one cycle after DONE entry; charCount=0.
- Bad code: second lookup returns code_len=0 -> error=1, busy=0, no second trn_go, charCount=1. A new start clears error.
- Start ignored while busy: pulse start during WAIT_TRN with totChar=7 -> pass completes with the original totChar=3 and base.
- Wait states: char_valid 6 cycles after req, code_valid 3 cycles after req -> char_req/code_req held high throughout; outputs are identical to the three-chars case.
